// File: rtl/multicycle_control_unit.sv
// Multicycle control unit: steps one instruction through EXEC/MEM/WB.
// Handles memory req/ack with timeout, and vector pixel load/store.
module multicycle_control_unit #(
  parameter int NUM_CH   = 3,
  parameter int CH_W     = 2,
  parameter int WAIT_MAX = 15
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            instr_valid,
  output logic            instr_ready,
  input  logic [1:0]      tipo,
  input  logic [1:0]      op,
  input  logic            Inm,
  input  logic            vec,
  input  logic            mem_ack,
  output logic            RegWrite,
  output logic [1:0]      ImmSrc,
  output logic            ALUSrc,
  output logic [1:0]      ALUOp,
  output logic            MemRead,
  output logic            MemWrite,
  output logic            ResultSrc,
  output logic            Branch,
  output logic            Jump,
  output logic            PCDirection,
  output logic            PCReturnSignal,
  output logic [CH_W-1:0] Channel,
  output logic            PCWrite,
  output logic            err
);

  localparam int CW = $clog2(WAIT_MAX + 1);
  localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WAIT_MAX - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_RETIRE,
    S_ERR
  } state_t;

  state_t state, next;

  logic [1:0]      tipo_q, op_q;
  logic            inm_q, vec_q;
  logic [CH_W-1:0] ch_q;
  logic [CW-1:0]   cnt;
  logic            err_q;

  logic is_load, is_store, more_ch;
  logic accept, timeout, illegal_in, advance;

  assign is_load  = (tipo_q == 2'b01) && (op_q != 2'b00);
  assign is_store = (tipo_q == 2'b11) && (op_q != 2'b00);
  assign more_ch  = vec_q && (ch_q < LAST_CH);

  assign accept     = (state == S_IDLE) && instr_valid;
  assign illegal_in = (tipo == 2'b10) && (op == 2'b11);
  assign timeout    = (state == S_MEM) && !mem_ack && (cnt == CNT_LAST);
  assign advance    = ((state == S_WB) && is_load && more_ch) ||
                      ((state == S_MEM) && mem_ack && is_store && more_ch);

  assign ImmSrc = 2'b00;
  assign err    = err_q;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= next;
  end

  // Latched instruction fields, channel, wait counter and sticky error
  always_ff @(posedge clk) begin
    if (rst) begin
      tipo_q <= '0;
      op_q   <= '0;
      inm_q  <= 1'b0;
      vec_q  <= 1'b0;
      ch_q   <= '0;
      cnt    <= '0;
      err_q  <= 1'b0;
    end else begin
      if (accept) begin
        tipo_q <= tipo;
        op_q   <= op;
        inm_q  <= Inm;
        vec_q  <= vec;
        ch_q   <= vec ? CH_W'(1) : CH_W'(op);
      end else if (advance) begin
        ch_q <= ch_q + CH_W'(1);
      end
      if ((state == S_MEM) && !mem_ack) cnt <= cnt + CW'(1);
      else                              cnt <= '0;
      if ((accept && illegal_in) || timeout) err_q <= 1'b1;
    end
  end

  // Next-state and Moore output decode
  always_comb begin
    next           = state;
    instr_ready    = 1'b0;
    RegWrite       = 1'b0;
    ALUSrc         = 1'b0;
    ALUOp          = 2'b00;
    MemRead        = 1'b0;
    MemWrite       = 1'b0;
    ResultSrc      = 1'b0;
    Branch         = 1'b0;
    Jump           = 1'b0;
    PCDirection    = 1'b0;
    PCReturnSignal = 1'b0;
    Channel        = '0;
    PCWrite        = 1'b0;
    unique case (state)
      S_IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid) begin
          unique case (1'b1)
            (tipo == 2'b00):                    next = S_EXEC;
            (tipo == 2'b01 && op == 2'b00):     next = S_WB;
            (tipo == 2'b10 && op == 2'b11):     next = S_ERR;
            (tipo == 2'b10 && op != 2'b11):     next = S_EXEC;
            (tipo == 2'b11 && op == 2'b00):     next = S_EXEC;
            default:                            next = S_MEM;
          endcase
        end
      end
      S_EXEC: begin
        next = S_IDLE;
        if (tipo_q == 2'b00) begin
          ALUOp  = 2'b10;
          ALUSrc = inm_q;
          next   = S_WB;
        end else begin
          PCWrite = 1'b1;
          case ({tipo_q, op_q})
            4'b1000: begin
              Jump        = 1'b1;
              PCDirection = inm_q;
            end
            4'b1001: begin
              Jump     = 1'b1;
              RegWrite = 1'b1;
            end
            4'b1010: begin
              Branch      = 1'b1;
              ALUOp       = 2'b01;
              PCDirection = inm_q;
            end
            default: begin
              Jump           = 1'b1;
              PCReturnSignal = 1'b1;
            end
          endcase
        end
      end
      S_MEM: begin
        MemRead  = (tipo_q == 2'b01);
        MemWrite = (tipo_q == 2'b11);
        ALUSrc   = inm_q;
        Channel  = ch_q;
        if (mem_ack) begin
          if (is_store) next = more_ch ? S_MEM : S_RETIRE;
          else          next = S_WB;
        end else if (cnt == CNT_LAST) begin
          next = S_IDLE;
        end
      end
      S_WB: begin
        RegWrite = 1'b1;
        next     = S_IDLE;
        if (tipo_q == 2'b00) begin
          PCWrite = 1'b1;
        end else if (op_q == 2'b00) begin
          ALUSrc  = inm_q;
          PCWrite = 1'b1;
        end else begin
          ResultSrc = 1'b1;
          Channel   = ch_q;
          PCWrite   = !more_ch;
          if (more_ch) next = S_MEM;
        end
      end
      S_RETIRE: begin
        PCWrite = 1'b1;
        next    = S_IDLE;
      end
      S_ERR: next = S_IDLE;
      default: next = S_IDLE;
    endcase
  end

endmodule
